// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - load/store bus between control unit and data memory responder
// Purpose: bundles the request strobes, address/data and the completion/stall/error
//          responses of the data memory port.
// Signals:
//   mem_read, mem_write  load / store request levels (control unit -> responder)
//   addr                 byte address (ALU result)
//   wdata                store data
//   rdata                registered load data (responder -> control unit)
//   ready                one-cycle completion pulse
//   stall                combinational pipeline hold
//   err                  one-cycle pulse for misaligned or conflicting requests
// Modports: master = control unit side, slave = responder side.
interface data_mem_responder_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              stall;
    logic              err;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, ready, stall, err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, ready, stall, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data memory responder with programmable wait states
// Purpose: accepts word load/store requests, waits WAIT_CYCLES cycles, then performs
//          the access on an internal RAM and pulses ready for one cycle.
// Ports:
//   i_clk   clock, rising edge
//   i_rst   asynchronous reset, active-high
//   io_mem  data_mem_responder_if.slave (mem_read, mem_write, addr, wdata in;
//           rdata, ready, stall, err out)
module data_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    data_mem_responder_if.slave   io_mem
);
    localparam int WORD_W = ADDR_W - 2;
    localparam int DEPTH  = 1 << WORD_W;
    localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic                r_op_write;
    logic [WORD_W-1:0]   r_word;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [DATA_W-1:0]   r_ram [DEPTH];

    logic                w_req;
    logic                w_illegal;
    logic                w_legal;
    logic                w_stall;
    logic                w_access;
    logic                w_acc_write;
    logic [WORD_W-1:0]   w_acc_word;
    logic [DATA_W-1:0]   w_acc_wdata;

    assign w_req     = io_mem.mem_read | io_mem.mem_write;
    assign w_illegal = w_req & ((io_mem.addr[1:0] != 2'b00) | (io_mem.mem_read & io_mem.mem_write));
    assign w_legal   = w_req & ~w_illegal;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The access source is normally the latched request; with zero wait states the
    // access happens on the accepting edge, so it is taken straight from the bus.
    always_comb begin
        w_next      = r_state;
        w_stall     = 1'b0;
        w_access    = 1'b0;
        w_acc_write = r_op_write;
        w_acc_word  = r_word;
        w_acc_wdata = r_wdata;
        case (r_state)
            S_IDLE: begin
                if (w_legal) begin
                    w_stall = 1'b1;
                    if (ZERO_WAIT) begin
                        w_next      = S_RESP;
                        w_access    = 1'b1;
                        w_acc_write = io_mem.mem_write;
                        w_acc_word  = io_mem.addr[ADDR_W-1:2];
                        w_acc_wdata = io_mem.wdata;
                    end else begin
                        w_next = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                w_stall = 1'b1;
                if (r_cnt == 4'd1) begin
                    w_access = 1'b1;
                    w_next   = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // Reset drops any in-flight access and releases the pipeline immediately.
        if (i_rst) begin
            w_stall  = 1'b0;
            w_access = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt      <= 4'd0;
            r_op_write <= 1'b0;
            r_word     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= (r_state == S_IDLE) & w_illegal;
            if (r_state == S_IDLE && w_legal) begin
                r_cnt      <= 4'(WAIT_CYCLES);
                r_op_write <= io_mem.mem_write;
                r_word     <= io_mem.addr[ADDR_W-1:2];
                r_wdata    <= io_mem.wdata;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access && !w_acc_write) begin
                r_rdata <= r_ram[w_acc_word];
            end
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge i_clk) begin
        if (w_access && w_acc_write) begin
            r_ram[w_acc_word] <= w_acc_wdata;
        end
    end

    assign io_mem.rdata = r_rdata;
    assign io_mem.ready = (r_state == S_RESP);
    assign io_mem.stall = w_stall;
    assign io_mem.err   = r_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_responder_if #(.ADDR_W(10), .DATA_W(32)) m2 ();
    data_mem_responder_if #(.ADDR_W(10), .DATA_W(32)) m0 ();

    data_mem_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(2)) u_dut2 (
        .i_clk (clk),
        .i_rst (rst),
        .io_mem(m2)
    );
    data_mem_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(0)) u_dut0 (
        .i_clk (clk),
        .i_rst (rst),
        .io_mem(m0)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: an accepted request at cycle n owns the port until
    // its ready cycle n+W+1; the access takes effect on entry to that ready cycle.
    int           cyc = 0;
    int           resp_cyc [2] = '{-1, -1};
    logic         err_q    [2] = '{1'b0, 1'b0};
    logic [31:0]  rdata_q  [2] = '{32'h0, 32'h0};
    logic         op_w     [2];
    logic [7:0]   word_q   [2];
    logic [31:0]  data_q   [2];
    logic [31:0]  mem_m    [2][256];

    task automatic model_dut(input int d, input int w, input logic mr, input logic mw,
                             input logic [9:0] a, input logic [31:0] wd,
                             input logic st, input logic rdy, input logic er,
                             input logic [31:0] rdv);
        logic accept, busy, req, illegal, legal;
        if (rst) begin
            resp_cyc[d] = -1;
            err_q[d]    = 1'b0;
            rdata_q[d]  = 32'h0;
            check($sformatf("model%0d_rst_stall", d), {31'b0, st}, 32'h0);
            check($sformatf("model%0d_rst_ready", d), {31'b0, rdy}, 32'h0);
            check($sformatf("model%0d_rst_err", d), {31'b0, er}, 32'h0);
            check($sformatf("model%0d_rst_rdata", d), rdv, 32'h0);
            return;
        end
        busy    = (resp_cyc[d] >= 0) && (cyc < resp_cyc[d]);
        accept  = !((resp_cyc[d] >= 0) && (cyc <= resp_cyc[d]));
        req     = mr | mw;
        illegal = req && ((a[1:0] != 2'b00) || (mr && mw));
        legal   = req && !illegal;
        check($sformatf("model%0d_stall@%0d", d, cyc), {31'b0, st}, {31'b0, busy || (accept && legal)});
        check($sformatf("model%0d_ready@%0d", d, cyc), {31'b0, rdy}, {31'b0, cyc == resp_cyc[d]});
        check($sformatf("model%0d_err@%0d", d, cyc), {31'b0, er}, {31'b0, err_q[d]});
        check($sformatf("model%0d_rdata@%0d", d, cyc), rdv, rdata_q[d]);
        err_q[d] = accept && illegal;
        if (accept && legal) begin
            resp_cyc[d] = cyc + w + 1;
            op_w[d]     = mw;
            word_q[d]   = a[9:2];
            data_q[d]   = wd;
        end
        if (resp_cyc[d] >= 0 && cyc + 1 == resp_cyc[d]) begin
            if (op_w[d]) mem_m[d][word_q[d]] = data_q[d];
            else         rdata_q[d] = mem_m[d][word_q[d]];
        end
    endtask

    always @(negedge clk) begin
        model_dut(0, 2, m2.mem_read, m2.mem_write, m2.addr, m2.wdata, m2.stall, m2.ready, m2.err, m2.rdata);
        model_dut(1, 0, m0.mem_read, m0.mem_write, m0.addr, m0.wdata, m0.stall, m0.ready, m0.err, m0.rdata);
        cyc++;
    end

    task automatic set_in(input int d, input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] wd);
        if (d == 0) begin
            m2.mem_read = rd; m2.mem_write = wr; m2.addr = a; m2.wdata = wd;
        end else begin
            m0.mem_read = rd; m0.mem_write = wr; m0.addr = a; m0.wdata = wd;
        end
    endtask

    function automatic logic get_ready(input int d);
        return (d == 0) ? m2.ready : m0.ready;
    endfunction
    function automatic logic get_stall(input int d);
        return (d == 0) ? m2.stall : m0.stall;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Holds the request until ready (bounded), then drops the strobes.
    task automatic access(input int d, input logic rd, input logic wr, input logic [9:0] a,
                          input logic [31:0] wd, output int lat, output logic [31:0] smask,
                          output logic [31:0] rdv);
        set_in(d, rd, wr, a, wd);
        lat = -1;
        smask = 32'h0;
        rdv = 32'h0;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            @(negedge clk);
            smask[k] = get_stall(d);
            if (get_ready(d)) begin
                lat = k;
                rdv = (d == 0) ? m2.rdata : m0.rdata;
            end
        end
        next_cycle();
        set_in(d, 1'b0, 1'b0, 10'h0, 32'h0);
    endtask

    int          lat;
    logic [31:0] smask;
    logic [31:0] rdv;
    logic [9:0]  rmask5;
    logic [9:0]  smask5;

    initial begin
        set_in(0, 1'b0, 1'b0, 10'h0, 32'h0);
        set_in(1, 1'b0, 1'b0, 10'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", {31'b0, m2.ready}, 32'h0);
        check("reset_rdata", m2.rdata, 32'h0);
        rst = 1'b0;
        next_cycle();

        // 1: write then read with two wait states
        access(0, 1'b0, 1'b1, 10'h010, 32'hDEADBEEF, lat, smask, rdv);
        check("t1_wr_latency", lat, 32'd3);
        check("t1_wr_stall_mask", smask, 32'h7);
        access(0, 1'b1, 1'b0, 10'h010, 32'h0, lat, smask, rdv);
        check("t1_rd_latency", lat, 32'd3);
        check("t1_rd_data", rdv, 32'hDEADBEEF);

        // 2: misaligned read
        set_in(0, 1'b1, 1'b0, 10'h013, 32'h0);
        @(negedge clk);
        check("t2_stall_c0", {31'b0, m2.stall}, 32'h0);
        check("t2_err_c0", {31'b0, m2.err}, 32'h0);
        next_cycle();
        set_in(0, 1'b0, 1'b0, 10'h0, 32'h0);
        @(negedge clk);
        check("t2_err_c1", {31'b0, m2.err}, 32'h1);
        check("t2_ready_c1", {31'b0, m2.ready}, 32'h0);
        next_cycle();
        @(negedge clk);
        check("t2_err_c2", {31'b0, m2.err}, 32'h0);
        check("t2_rdata_kept", m2.rdata, 32'hDEADBEEF);
        next_cycle();

        // 3: conflicting strobes leave RAM untouched
        access(0, 1'b0, 1'b1, 10'h020, 32'h11111111, lat, smask, rdv);
        set_in(0, 1'b1, 1'b1, 10'h020, 32'h0);
        next_cycle();
        set_in(0, 1'b0, 1'b0, 10'h0, 32'h0);
        @(negedge clk);
        check("t3_err", {31'b0, m2.err}, 32'h1);
        next_cycle();
        access(0, 1'b1, 1'b0, 10'h020, 32'h0, lat, smask, rdv);
        check("t3_rd_data", rdv, 32'h11111111);

        // 4: reset during BUSY drops the write
        set_in(0, 1'b0, 1'b1, 10'h020, 32'hCAFEF00D);
        next_cycle();
        rst = 1'b1;
        set_in(0, 1'b0, 1'b0, 10'h0, 32'h0);
        #1;
        check("t4_rst_stall", {31'b0, m2.stall}, 32'h0);
        check("t4_rst_ready", {31'b0, m2.ready}, 32'h0);
        check("t4_rst_rdata", m2.rdata, 32'h0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        access(0, 1'b1, 1'b0, 10'h020, 32'h0, lat, smask, rdv);
        check("t4_rd_data", rdv, 32'h11111111);

        // 5: held read produces back-to-back accesses
        access(0, 1'b0, 1'b1, 10'h004, 32'h12345678, lat, smask, rdv);
        set_in(0, 1'b1, 1'b0, 10'h004, 32'h0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rmask5[k] = m2.ready;
            smask5[k] = m2.stall;
            next_cycle();
        end
        set_in(0, 1'b0, 1'b0, 10'h0, 32'h0);
        check("t5_ready_mask", {22'b0, rmask5}, 32'h088);
        check("t5_stall_mask", {22'b0, smask5}, 32'h377);
        repeat (4) next_cycle();
        check("t5_rdata", m2.rdata, 32'h12345678);

        // 6: zero wait states at the top word
        access(1, 1'b0, 1'b1, 10'h3FC, 32'hA5A55A5A, lat, smask, rdv);
        check("t6_wr_latency", lat, 32'd1);
        access(1, 1'b1, 1'b0, 10'h3FC, 32'h0, lat, smask, rdv);
        check("t6_rd_latency", lat, 32'd1);
        check("t6_rd_data", rdv, 32'hA5A55A5A);

        repeat (2) next_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
